// File: rtl/mixer_sched_pkg.sv
// Shared types for the mixer scheduler: FSM state encoding.
package mixer_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    FILL_A = 3'd1,
    FILL_B = 3'd2,
    MIX    = 3'd3,
    DRAIN  = 3'd4
  } mix_state_e;

endpackage

// File: rtl/mixer_scheduler_if.sv
// Request/valve bundle between request logic and the mixer scheduler.
// MIXER_SCHED_TIMEOUT_EN adds the fill_ok level sensor and the fault pulse.
interface mixer_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int CW    = 16
);
  logic [N_REQ-1:0] req;
  logic [CW-1:0]    fill_time;
  logic [CW-1:0]    mix_time;
  logic [CW-1:0]    drain_time;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] valve_a;
  logic [N_REQ-1:0] valve_b;
  logic             mix_pump;
  logic             drain_valve;
  logic [N_REQ-1:0] done;
  logic             busy;
`ifdef MIXER_SCHED_TIMEOUT_EN
  logic             fill_ok;
  logic             fault;

  modport master (
    output req, fill_time, mix_time, drain_time, fill_ok,
    input  grant, valve_a, valve_b, mix_pump, drain_valve, done, busy, fault
  );
  modport slave (
    input  req, fill_time, mix_time, drain_time, fill_ok,
    output grant, valve_a, valve_b, mix_pump, drain_valve, done, busy, fault
  );
`else
  modport master (
    output req, fill_time, mix_time, drain_time,
    input  grant, valve_a, valve_b, mix_pump, drain_valve, done, busy
  );
  modport slave (
    input  req, fill_time, mix_time, drain_time,
    output grant, valve_a, valve_b, mix_pump, drain_valve, done, busy
  );
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit searching upward from ptr.
// Zero latency; gnt is all-zero when no request is set.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      // ptr + i never exceeds 2N-2, so one conditional subtract is a full modulo
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mixer_scheduler.sv
// Shares one mixer among N_REQ chambers: FILL_A, FILL_B, MIX, DRAIN per grant; grant one cycle after req in IDLE.
// No backpressure (level requests); MIXER_SCHED_TIMEOUT_EN aborts to DRAIN when fill_ok is low at fill end.
module mixer_scheduler
  import mixer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  mixer_scheduler_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  mix_state_e       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    mix_q, mix_d;
  logic [CW-1:0]    drain_q, drain_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
`ifdef MIXER_SCHED_TIMEOUT_EN
  logic             abort_q, abort_d;
  logic             fault_q, fault_d;
`endif

  // Latched values are stored pre-decremented; a duration of 0 behaves like 1.
  function automatic logic [CW-1:0] load_val(input logic [CW-1:0] dur);
    return (dur == '0) ? '0 : dur - 1'b1;
  endfunction

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    mix_d   = mix_q;
    drain_d = drain_q;
    done_d  = '0;
`ifdef MIXER_SCHED_TIMEOUT_EN
    abort_d = abort_q;
    fault_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          state_d = FILL_A;
          owner_d = arb_idx;
          ptr_d   = (arb_idx == IW'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
          fill_d  = load_val(bus.fill_time);
          mix_d   = load_val(bus.mix_time);
          drain_d = load_val(bus.drain_time);
          cnt_d   = load_val(bus.fill_time);
`ifdef MIXER_SCHED_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
      end
      FILL_A: begin
        if (cnt_q == '0) begin
`ifdef MIXER_SCHED_TIMEOUT_EN
          if (!bus.fill_ok) begin
            state_d = DRAIN;
            cnt_d   = drain_q;
            abort_d = 1'b1;
          end else begin
            state_d = FILL_B;
            cnt_d   = fill_q;
          end
`else
          state_d = FILL_B;
          cnt_d   = fill_q;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FILL_B: begin
        if (cnt_q == '0) begin
`ifdef MIXER_SCHED_TIMEOUT_EN
          if (!bus.fill_ok) begin
            state_d = DRAIN;
            cnt_d   = drain_q;
            abort_d = 1'b1;
          end else begin
            state_d = MIX;
            cnt_d   = mix_q;
          end
`else
          state_d = MIX;
          cnt_d   = mix_q;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MIX: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
          cnt_d   = drain_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = owner_oh;
`ifdef MIXER_SCHED_TIMEOUT_EN
          fault_d = abort_q;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      mix_q   <= '0;
      drain_q <= '0;
      done_q  <= '0;
`ifdef MIXER_SCHED_TIMEOUT_EN
      abort_q <= 1'b0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      mix_q   <= mix_d;
      drain_q <= drain_d;
      done_q  <= done_d;
`ifdef MIXER_SCHED_TIMEOUT_EN
      abort_q <= abort_d;
      fault_q <= fault_d;
`endif
    end
  end

  // Outputs decode straight from reset-cleared state, so reset closes every valve at once.
  always_comb begin
    bus.grant       = '0;
    bus.valve_a     = '0;
    bus.valve_b     = '0;
    bus.mix_pump    = 1'b0;
    bus.drain_valve = 1'b0;
    bus.busy        = (state_q != IDLE);
    bus.done        = done_q;
    case (state_q)
      FILL_A: begin
        bus.grant   = owner_oh;
        bus.valve_a = owner_oh;
      end
      FILL_B: begin
        bus.grant   = owner_oh;
        bus.valve_b = owner_oh;
      end
      MIX: begin
        bus.grant    = owner_oh;
        bus.mix_pump = 1'b1;
      end
      DRAIN: begin
        bus.grant       = owner_oh;
        bus.drain_valve = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MIXER_SCHED_TIMEOUT_EN
  assign bus.fault = fault_q;
`endif

endmodule

// File: tb/tb_mixer_scheduler.sv
// Directed self-checking bench for mixer_scheduler (N_REQ=4, CW=16).
module tb_mixer_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mixer_scheduler_if #(.N_REQ(4), .CW(16)) bus ();

  mixer_scheduler #(.N_REQ(4), .CW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    logic [19:0] outs;
    rst = 1'b1;
    bus.req = '0;
    bus.fill_time = '0;
    bus.mix_time = '0;
    bus.drain_time = '0;
`ifdef MIXER_SCHED_TIMEOUT_EN
    bus.fill_ok = 1'b1;
`endif
    @(negedge clk);
    outs = {bus.grant, bus.valve_a, bus.valve_b, bus.mix_pump, bus.drain_valve, bus.done, bus.busy, 1'b0};
    n_cmp++;
    if (outs !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 00000", outs);
    end
`ifdef MIXER_SCHED_TIMEOUT_EN
    n_cmp++;
    if (bus.fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fault got %b want 0", bus.fault);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_single();
    int na = 0, nb = 0, nm = 0, nd = 0, early = 0, viol = 0;
    int fb = -1, fm = -1, fd = -1;
    logic [3:0] gnt0 = '0, done13 = '0;
    bus.fill_time = 16'd3;
    bus.mix_time = 16'd5;
    bus.drain_time = 16'd2;
    bus.req = 4'b0010;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        gnt0 = bus.grant;
        bus.req = '0;
      end
      if ($countones({bus.valve_a, bus.valve_b, bus.mix_pump, bus.drain_valve}) > 1) viol++;
      if (bus.valve_a == 4'b0010) na++;
      if (bus.valve_b == 4'b0010) begin nb++; if (fb < 0) fb = c; end
      if (bus.mix_pump) begin nm++; if (fm < 0) fm = c; end
      if (bus.drain_valve) begin nd++; if (fd < 0) fd = c; end
      if (c < 13 && bus.done != '0) early++;
      if (c == 13) done13 = bus.done;
    end
    n_cmp++; if (gnt0 !== 4'b0010) begin n_err++; $display("FAIL single_grant got %b want 0010", gnt0); end
    n_cmp++; if (na != 3) begin n_err++; $display("FAIL single_fill_a_len got %0d want 3", na); end
    n_cmp++; if (nb != 3) begin n_err++; $display("FAIL single_fill_b_len got %0d want 3", nb); end
    n_cmp++; if (nm != 5) begin n_err++; $display("FAIL single_mix_len got %0d want 5", nm); end
    n_cmp++; if (nd != 2) begin n_err++; $display("FAIL single_drain_len got %0d want 2", nd); end
    n_cmp++; if (fb != 3) begin n_err++; $display("FAIL single_fill_b_start got %0d want 3", fb); end
    n_cmp++; if (fm != 6) begin n_err++; $display("FAIL single_mix_start got %0d want 6", fm); end
    n_cmp++; if (fd != 11) begin n_err++; $display("FAIL single_drain_start got %0d want 11", fd); end
    n_cmp++; if (done13 !== 4'b0010) begin n_err++; $display("FAIL single_done got %b want 0010", done13); end
    n_cmp++; if (early != 0) begin n_err++; $display("FAIL single_early_done got %0d want 0", early); end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL single_exclusive got %0d want 0", viol); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    logic [3:0] seq [5];
    int gap [5];
    int k = 0, zero_run = 0, done_bad = 0;
    logic [3:0] prev = '0;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin seq[i] = '0; gap[i] = -1; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.fill_time = 16'd1;
    bus.mix_time = 16'd1;
    bus.drain_time = 16'd1;
    bus.req = 4'b1111;
    for (int c = 0; c < 60 && k < 5; c++) begin
      @(negedge clk);
      if (bus.grant != '0 && prev == '0) begin
        seq[k] = bus.grant;
        gap[k] = zero_run;
        k++;
        zero_run = 0;
      end else if (bus.grant == '0) begin
        zero_run++;
        if (prev != '0 && bus.done !== prev) done_bad++;
      end
      prev = bus.grant;
    end
    bus.req = '0;
    n_cmp++; if (k != 5) begin n_err++; $display("FAIL rr_grant_count got %0d want 5", k); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (seq[i] !== exp_seq[i]) begin
        n_err++;
        $display("FAIL rr_order[%0d] got %b want %b", i, seq[i], exp_seq[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (gap[i] != 1) begin n_err++; $display("FAIL rr_gap[%0d] got %0d want 1", i, gap[i]); end
    end
    n_cmp++; if (done_bad != 0) begin n_err++; $display("FAIL rr_done_in_gap got %0d want 0", done_bad); end
    wait_idle("rr_drain");
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (c < 40 && (bus.busy !== 1'b0 || bus.done !== 4'b0)) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c >= 40) begin n_err++; $display("FAIL %s_idle_timeout got busy=%b want 0", name, bus.busy); end
  endtask

  task automatic test_zero_durations();
    logic [13:0] exp_z [5];
    logic [13:0] got;
    exp_z[0] = {4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000};
    exp_z[1] = {4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0000};
    exp_z[2] = {4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000};
    exp_z[3] = {4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
    exp_z[4] = {4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100};
    bus.fill_time = '0;
    bus.mix_time = '0;
    bus.drain_time = '0;
    bus.req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) bus.req = '0;
      got = {bus.valve_a, bus.valve_b, bus.mix_pump, bus.drain_valve, bus.done};
      n_cmp++;
      if (got !== exp_z[c]) begin
        n_err++;
        $display("FAIL zero_cycle[%0d] got %b want %b", c, got, exp_z[c]);
      end
    end
    wait_idle("zero");
  endtask

  task automatic test_mid_change();
    int nm = 0, extra = 0;
    logic [3:0] done7 = '0;
    logic drain6 = 1'b0;
    bus.fill_time = 16'd1;
    bus.mix_time = 16'd4;
    bus.drain_time = 16'd1;
    bus.req = 4'b1000;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) bus.req = '0;
      if (c == 3) begin
        bus.mix_time = 16'd20;
        bus.fill_time = 16'd9;
        bus.drain_time = 16'd7;
      end
      if (bus.mix_pump) nm++;
      if (c == 6) drain6 = bus.drain_valve;
      if (c == 7) done7 = bus.done;
      if (c > 7 && (bus.done != '0 || bus.grant != '0)) extra++;
    end
    n_cmp++; if (nm != 4) begin n_err++; $display("FAIL mid_mix_len got %0d want 4", nm); end
    n_cmp++; if (drain6 !== 1'b1) begin n_err++; $display("FAIL mid_drain_at6 got %b want 1", drain6); end
    n_cmp++; if (done7 !== 4'b1000) begin n_err++; $display("FAIL mid_done got %b want 1000", done7); end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL mid_extra_activity got %0d want 0", extra); end
  endtask

  task automatic test_async_reset();
    logic [15:0] outs;
    bus.fill_time = 16'd1;
    bus.mix_time = 16'd8;
    bus.drain_time = 16'd1;
    bus.req = 4'b0100;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.mix_pump !== 1'b1) begin n_err++; $display("FAIL arst_pre_mix got %b want 1", bus.mix_pump); end
    bus.req = 4'b1111;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.mix_pump !== 1'b0) begin n_err++; $display("FAIL arst_pump_off got %b want 0", bus.mix_pump); end
    outs = {bus.grant, bus.valve_a, bus.valve_b, bus.busy, bus.drain_valve, 2'b00};
    n_cmp++;
    if (outs !== 16'h0) begin n_err++; $display("FAIL arst_outputs got %h want 0000", outs); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL arst_release_grant got %b want 0000", bus.grant); end
    @(negedge clk);
    n_cmp++;
    if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL arst_first_grant got %b want 0001", bus.grant); end
    bus.req = '0;
    wait_idle("arst");
  endtask

`ifdef MIXER_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int nm = 0;
    logic drain4 = 1'b0;
    logic [4:0] end6 = '0;
    logic fault7 = 1'b1;
    bus.fill_time = 16'd2;
    bus.mix_time = 16'd3;
    bus.drain_time = 16'd2;
    bus.fill_ok = 1'b1;
    bus.req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) bus.req = '0;
      if (c == 2) bus.fill_ok = 1'b0;
      if (bus.mix_pump) nm++;
      if (c == 4) drain4 = bus.drain_valve;
      if (c == 6) end6 = {bus.done, bus.fault};
      if (c == 7) fault7 = bus.fault;
    end
    bus.fill_ok = 1'b1;
    n_cmp++; if (nm != 0) begin n_err++; $display("FAIL tmo_no_mix got %0d want 0", nm); end
    n_cmp++; if (drain4 !== 1'b1) begin n_err++; $display("FAIL tmo_drain got %b want 1", drain4); end
    n_cmp++; if (end6 !== 5'b00101) begin n_err++; $display("FAIL tmo_done_fault got %b want 00101", end6); end
    n_cmp++; if (fault7 !== 1'b0) begin n_err++; $display("FAIL tmo_fault_pulse got %b want 0", fault7); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_durations();
    test_mid_change();
    test_async_reset();
`ifdef MIXER_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
